weight_bank_scheduler: RTL and testbench
========================================

WEIGHT_BANK_SCHEDULER -- requirements
Module: weight_bank_scheduler

Parameters
REQ-001 Amba_Addr_Depth, default 12: bank address width (12/13/14).
REQ-002 WeightRowWidth, default 15: bank row width, WeightPrecision*3 (15/24/48).

Interface
REQ-003 clock  input  1  single clock; all logic on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 host_req  input  1  host transfer request; held stable, with host_write/addr/wdata, until host_ack.
REQ-006 host_write  input  1  1 = write, 0 = read.
REQ-007 host_addr  input  Amba_Addr_Depth  host row address.
REQ-008 host_wdata  input  WeightRowWidth  host write row.
REQ-009 host_ack  output  1  one-cycle transfer-complete pulse.
REQ-010 host_rdata  output  WeightRowWidth  read row, valid while host_ack=1 on a read.
REQ-011 strm_start  input  1  one-cycle pulse starting a streaming burst.
REQ-012 strm_base  input  Amba_Addr_Depth  burst start row, sampled with strm_start.
REQ-013 strm_len  input  Amba_Addr_Depth  burst row count, sampled with strm_start.
REQ-014 strm_ready  input  1  consumer can take a row one cycle later.
REQ-015 strm_valid  output  1  strm_data holds a weight row this cycle.
REQ-016 strm_data  output  WeightRowWidth  streamed row.
REQ-017 strm_last  output  1  marks the final row of a burst.
REQ-018 strm_busy  output  1  burst in progress.
REQ-019 strm_done  output  1  one-cycle burst-complete pulse.
REQ-020 bank_control  output  2  weight bank command: 01 = WRITE, 10 = READ, 00 = idle; registered.
REQ-021 bank_address  output  Amba_Addr_Depth  bank row address; registered.
REQ-022 bank_wdata  output  WeightRowWidth  bank write row; registered.
REQ-023 bank_rdata  input  WeightRowWidth  bank read row, valid the cycle after a READ command.

Function
REQ-024 The FSM SHALL have the states IDLE, HOST_WR, HOST_RD, STREAM and DRAIN, with exactly one bank command issued per cycle at most.
REQ-025 A host request SHALL be edge-armed: it is granted only if host_req was observed low after the previous host_ack.
REQ-026 Host write: when the grant is decided at edge k, bank_control=01 SHALL hold with host_addr/host_wdata in cycle k+1, and host_ack SHALL be 1 in cycle k+1.
REQ-027 Host read: when the grant is decided at edge k, bank_control=10 SHALL hold in cycle k+1, and host_ack=1 SHALL be asserted in cycle k+2 with host_rdata=bank_rdata.
REQ-028 strm_start in IDLE SHALL latch base/len, set strm_busy the next cycle and enter STREAM; strm_start while strm_busy=1 SHALL be ignored.
REQ-029 In STREAM, each cycle with strm_ready=1 and a stream slot SHALL issue READ at the address pointer, then increment the pointer modulo 2**Amba_Addr_Depth (wrap to 0) and decrement the remaining count.
REQ-030 A READ issued in cycle n SHALL produce strm_valid=1 and strm_data=bank_rdata in cycle n+1.
REQ-031 strm_ready=0 SHALL issue no stream READ that cycle, with the pointer and count held.
REQ-032 Arbitration: while the host is armed in STREAM, slots SHALL alternate stream/host (host one slot, then at least one stream slot); a host read's return cycle SHALL not collide with a stream return.
REQ-033 After the final READ, the FSM SHALL go to DRAIN; strm_last and strm_done SHALL be 1 together with the final strm_valid, and strm_busy SHALL drop in the next cycle.
REQ-034 strm_len=0 SHALL issue no reads, pulse strm_done the cycle after strm_start with strm_valid=0, and pulse strm_busy for one cycle.
REQ-035 strm_len=1 SHALL produce a single beat with strm_last=1.
REQ-036 Simultaneous strm_start and an armed host_req in IDLE SHALL serve the host first, then start the burst.

Reset
REQ-037 reset=0 SHALL immediately clear the state to IDLE and drive all outputs to 0 (bank_control=00), discarding any burst or host transfer in flight, with no ack or done.
REQ-038 After reset release, host_req already high SHALL count as armed.

Verification
REQ-039 Host write 0x0A5 to row 3, then host read row 3 -> bank_control 01 then 10; host_ack on the read 2 cycles after grant; host_rdata=0x0A5.
REQ-040 Burst base=4092, len=6, Amba_Addr_Depth=12, strm_ready=1 -> addresses 4092..4095, 0, 1; six strm_valid; strm_last/strm_done on the 6th beat.
REQ-041 Burst len=8 with strm_ready toggling 1,0,1,0 -> exactly 8 beats in order, no duplicate or missing rows.
REQ-042 Host read armed mid-burst (len=10) -> host and stream READ slots alternate; all 10 stream rows and host_rdata correct.
REQ-043 strm_len=0 -> strm_done the next cycle, no bank_control=10; strm_start while busy -> ignored.
REQ-044 reset=0 asserted on the 3rd beat of a len=8 burst -> outputs 0 asynchronously; after release, a new len=2 burst completes normally.

Source files
------------

// File: rtl/weight_bank_scheduler.sv
// Schedules a single-ported weight bank between host row transfers and
// streaming bursts. Bank commands are registered and read data returns one cycle later.
module weight_bank_scheduler #(
    parameter int Amba_Addr_Depth = 12,
    parameter int WeightRowWidth  = 15
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       host_req,
    input  logic                       host_write,
    input  logic [Amba_Addr_Depth-1:0] host_addr,
    input  logic [WeightRowWidth-1:0]  host_wdata,
    output logic                       host_ack,
    output logic [WeightRowWidth-1:0]  host_rdata,
    input  logic                       strm_start,
    input  logic [Amba_Addr_Depth-1:0] strm_base,
    input  logic [Amba_Addr_Depth-1:0] strm_len,
    input  logic                       strm_ready,
    output logic                       strm_valid,
    output logic [WeightRowWidth-1:0]  strm_data,
    output logic                       strm_last,
    output logic                       strm_busy,
    output logic                       strm_done,
    output logic [1:0]                 bank_control,
    output logic [Amba_Addr_Depth-1:0] bank_address,
    output logic [WeightRowWidth-1:0]  bank_wdata,
    input  logic [WeightRowWidth-1:0]  bank_rdata
);

    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;
    localparam logic [Amba_Addr_Depth-1:0] ADDR_ONE = 1;

    typedef enum logic [2:0] {IDLE, HOST_WR, HOST_RD, STREAM, DRAIN} state_t;

    state_t                     state, state_d;
    logic                       armed, armed_d;
    logic                       host_last, host_last_d;
    logic                       start_pending, start_pending_d;
    logic [Amba_Addr_Depth-1:0] ptr, ptr_d;
    logic [Amba_Addr_Depth-1:0] remaining, remaining_d;
    logic                       host_rd_ret, host_rd_ret_d;
    logic                       host_ack_rd, host_ack_rd_d;
    logic                       strm_rd_ret, strm_rd_ret_d;
    logic                       last_ret, last_ret_d;
    logic [1:0]                 bank_control_d;
    logic [Amba_Addr_Depth-1:0] bank_address_d;
    logic [WeightRowWidth-1:0]  bank_wdata_d;
    logic                       host_ack_d, strm_valid_d, strm_last_d;
    logic                       strm_done_d, strm_busy_d;
    logic                       host_grant, launch, start_ok;

    // Read data is a pass-through of the bank, qualified by the return flags.
    assign host_rdata = host_ack_rd ? bank_rdata : '0;
    assign strm_data  = strm_valid  ? bank_rdata : '0;
    assign start_ok   = strm_start && !strm_busy;

    always_comb begin
        state_d         = state;
        armed_d         = host_req ? armed : 1'b1;
        host_last_d     = host_last;
        start_pending_d = start_pending;
        ptr_d           = ptr;
        remaining_d     = remaining;
        host_rd_ret_d   = 1'b0;
        host_ack_rd_d   = host_rd_ret;
        strm_rd_ret_d   = 1'b0;
        last_ret_d      = 1'b0;
        bank_control_d  = CMD_IDLE;
        bank_address_d  = '0;
        bank_wdata_d    = '0;
        host_ack_d      = host_rd_ret;
        strm_valid_d    = strm_rd_ret;
        strm_last_d     = last_ret;
        strm_done_d     = last_ret;
        strm_busy_d     = strm_busy;
        host_grant      = 1'b0;
        launch          = 1'b0;

        case (state)
            IDLE: begin
                strm_busy_d = 1'b0;
                host_last_d = 1'b0;
                // A host request wins over a simultaneous burst start; the burst waits as pending.
                if (host_req && armed) begin
                    host_grant = 1'b1;
                    state_d    = host_write ? HOST_WR : HOST_RD;
                    if (start_ok) begin
                        start_pending_d = 1'b1;
                        ptr_d           = strm_base;
                        remaining_d     = strm_len;
                        strm_busy_d     = 1'b1;
                    end
                end else if (start_ok) begin
                    ptr_d       = strm_base;
                    remaining_d = strm_len;
                    launch      = 1'b1;
                end
            end
            HOST_WR, HOST_RD: begin
                state_d         = IDLE;
                start_pending_d = 1'b0;
                if (start_ok) begin
                    ptr_d       = strm_base;
                    remaining_d = strm_len;
                    launch      = 1'b1;
                end else if (start_pending) begin
                    launch = 1'b1;
                end
            end
            STREAM: begin
                // host_last forces a stream slot between consecutive host slots.
                if (host_req && armed && !host_last) begin
                    host_grant  = 1'b1;
                    host_last_d = 1'b1;
                end else if (strm_ready) begin
                    bank_control_d = CMD_READ;
                    bank_address_d = ptr;
                    ptr_d          = ptr + ADDR_ONE;
                    remaining_d    = remaining - ADDR_ONE;
                    strm_rd_ret_d  = 1'b1;
                    host_last_d    = 1'b0;
                    if (remaining == ADDR_ONE) begin
                        last_ret_d = 1'b1;
                        state_d    = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (strm_done) begin
                    state_d     = IDLE;
                    strm_busy_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // An empty burst completes immediately without touching the bank.
        if (launch) begin
            strm_busy_d = 1'b1;
            host_last_d = 1'b0;
            if (remaining_d == '0) begin
                strm_done_d = 1'b1;
                state_d     = IDLE;
            end else begin
                state_d = STREAM;
            end
        end

        if (host_grant) begin
            armed_d        = 1'b0;
            bank_address_d = host_addr;
            if (host_write) begin
                bank_control_d = CMD_WRITE;
                bank_wdata_d   = host_wdata;
                host_ack_d     = 1'b1;
            end else begin
                bank_control_d = CMD_READ;
                host_rd_ret_d  = 1'b1;
            end
        end
    end

    // armed resets to 1 so a request already high at release is served.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            armed         <= 1'b1;
            host_last     <= 1'b0;
            start_pending <= 1'b0;
            ptr           <= '0;
            remaining     <= '0;
            host_rd_ret   <= 1'b0;
            host_ack_rd   <= 1'b0;
            strm_rd_ret   <= 1'b0;
            last_ret      <= 1'b0;
            bank_control  <= CMD_IDLE;
            bank_address  <= '0;
            bank_wdata    <= '0;
            host_ack      <= 1'b0;
            strm_valid    <= 1'b0;
            strm_last     <= 1'b0;
            strm_done     <= 1'b0;
            strm_busy     <= 1'b0;
        end else begin
            state         <= state_d;
            armed         <= armed_d;
            host_last     <= host_last_d;
            start_pending <= start_pending_d;
            ptr           <= ptr_d;
            remaining     <= remaining_d;
            host_rd_ret   <= host_rd_ret_d;
            host_ack_rd   <= host_ack_rd_d;
            strm_rd_ret   <= strm_rd_ret_d;
            last_ret      <= last_ret_d;
            bank_control  <= bank_control_d;
            bank_address  <= bank_address_d;
            bank_wdata    <= bank_wdata_d;
            host_ack      <= host_ack_d;
            strm_valid    <= strm_valid_d;
            strm_last     <= strm_last_d;
            strm_done     <= strm_done_d;
            strm_busy     <= strm_busy_d;
        end
    end

endmodule

// File: tb/tb_weight_bank_scheduler.sv
// Scoreboard bench for weight_bank_scheduler: a bank memory model, expected
// host/stream responses queued at issue time and popped by a separate monitor.
module tb_weight_bank_scheduler;

    localparam int AW    = 12;
    localparam int RW    = 15;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          host_req = 1'b0, host_write = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [RW-1:0] host_wdata = '0;
    logic          host_ack;
    logic [RW-1:0] host_rdata;
    logic          strm_start = 1'b0;
    logic [AW-1:0] strm_base = '0, strm_len = '0;
    logic          strm_ready = 1'b0;
    logic          strm_valid, strm_last, strm_busy, strm_done;
    logic [RW-1:0] strm_data;
    logic [1:0]    bank_control;
    logic [AW-1:0] bank_address;
    logic [RW-1:0] bank_wdata;
    logic [RW-1:0] bank_rdata = '0;

    always #5 clock = ~clock;

    weight_bank_scheduler #(.Amba_Addr_Depth(AW), .WeightRowWidth(RW)) dut (
        .clock(clock), .reset(reset),
        .host_req(host_req), .host_write(host_write), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .strm_start(strm_start), .strm_base(strm_base), .strm_len(strm_len),
        .strm_ready(strm_ready), .strm_valid(strm_valid), .strm_data(strm_data),
        .strm_last(strm_last), .strm_busy(strm_busy), .strm_done(strm_done),
        .bank_control(bank_control), .bank_address(bank_address),
        .bank_wdata(bank_wdata), .bank_rdata(bank_rdata)
    );

    // Bank model: writes land at the edge, reads return one cycle after the command.
    logic [RW-1:0] bank_mem [DEPTH];
    logic [RW-1:0] shadow   [DEPTH];

    always @(posedge clock) begin
        if (bank_control == 2'b01) bank_mem[bank_address] <= bank_wdata;
        if (bank_control == 2'b10) bank_rdata <= bank_mem[bank_address];
    end

    typedef struct {bit wr; logic [AW-1:0] addr; logic [RW-1:0] data;} host_exp_t;
    typedef struct {logic [RW-1:0] data; bit last;} beat_t;

    host_exp_t host_q[$];
    beat_t     strm_q[$];
    int errors = 0, checks = 0;
    int beats_seen = 0, done_seen = 0, rd_cmds = 0, zero_done_pending = 0;
    int ready_mode = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Consumer ready pattern: 0 = always ready, 1 = toggling, 2 = random.
    initial begin
        forever begin
            @(negedge clock);
            case (ready_mode)
                0:       strm_ready = 1'b1;
                1:       strm_ready = ~strm_ready;
                default: strm_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    initial begin
        bit prev_done = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                prev_done = 1'b0;
            end else begin
                if (prev_done) check_output("busy_drop_after_done", 32'(strm_busy), 32'd0);
                if (bank_control == 2'b10) rd_cmds++;
                if (strm_valid) begin
                    beats_seen++;
                    if (strm_q.size() == 0) begin
                        check_output("strm_unexpected_beat", 32'd1, 32'd0);
                    end else begin
                        beat_t b;
                        b = strm_q.pop_front();
                        check_output("strm_data", 32'(strm_data), 32'(b.data));
                        check_output("strm_last", 32'(strm_last), 32'(b.last));
                        check_output("strm_done_on_last", 32'(strm_done), 32'(b.last));
                        if (b.last) check_output("busy_on_done", 32'(strm_busy), 32'd1);
                    end
                end else begin
                    if (strm_last) check_output("strm_last_without_valid", 32'd1, 32'd0);
                    if (strm_done) begin
                        if (zero_done_pending > 0) zero_done_pending--;
                        else check_output("strm_done_without_valid", 32'd1, 32'd0);
                    end
                end
                if (strm_done) done_seen++;
                prev_done = strm_done;
                if (host_ack) begin
                    if (host_q.size() == 0) begin
                        check_output("host_unexpected_ack", 32'd1, 32'd0);
                    end else begin
                        host_exp_t h;
                        h = host_q.pop_front();
                        if (h.wr) begin
                            check_output("host_wr_cmd", 32'(bank_control), 32'd1);
                            check_output("host_wr_addr", 32'(bank_address), 32'(h.addr));
                            check_output("host_wr_data", 32'(bank_wdata), 32'(h.data));
                        end else begin
                            check_output("host_rdata", 32'(host_rdata), 32'(h.data));
                        end
                    end
                end
            end
        end
    end

    // Called just after a negedge; exp_lat=0 skips the latency comparison.
    task automatic host_txn(input bit wr, input logic [AW-1:0] addr,
                            input logic [RW-1:0] data, input int exp_lat);
        host_exp_t h;
        int n;
        h.wr   = wr;
        h.addr = addr;
        h.data = wr ? data : shadow[addr];
        if (wr) shadow[addr] = data;
        host_q.push_back(h);
        host_req   = 1'b1;
        host_write = wr;
        host_addr  = addr;
        host_wdata = data;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!host_ack && n < 60);
        if (!host_ack) check_output("host_ack_timeout", 32'd0, 32'd1);
        else if (exp_lat > 0) check_output("host_ack_latency", 32'(n), 32'(exp_lat));
        host_req = 1'b0;
    endtask

    task automatic apply_stimulus_burst(input logic [AW-1:0] base, input logic [AW-1:0] len);
        beat_t b;
        for (int i = 0; i < int'(len); i++) begin
            b.data = shadow[(int'(base) + i) % DEPTH];
            b.last = (i == int'(len) - 1);
            strm_q.push_back(b);
        end
        if (len == '0) zero_done_pending++;
        strm_start = 1'b1;
        strm_base  = base;
        strm_len   = len;
        @(negedge clock);
        strm_start = 1'b0;
    endtask

    task automatic wait_done(input int prior, input string name);
        int n = 0;
        while (done_seen <= prior && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (done_seen <= prior) check_output({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r0, d0, b0, n;
        logic [AW-1:0] base, len;
        for (int i = 0; i < DEPTH; i++) begin
            bank_mem[i] = RW'(i * 7 + 341);
            shadow[i]   = RW'(i * 7 + 341);
        end
        repeat (3) @(negedge clock);
        check_output("reset_host_ack", 32'(host_ack), 32'd0);
        check_output("reset_strm_busy", 32'(strm_busy), 32'd0);
        check_output("reset_bank_control", 32'(bank_control), 32'd0);
        check_output("reset_strm_valid", 32'(strm_valid), 32'd0);

        // Host write to row 3 with request already high across reset release.
        shadow[3] = 15'h0A5;
        host_q.push_back('{wr: 1'b1, addr: 12'd3, data: 15'h0A5});
        host_req = 1'b1; host_write = 1'b1; host_addr = 12'd3; host_wdata = 15'h0A5;
        @(negedge clock);
        reset = 1'b1;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!host_ack && n < 60);
        check_output("armed_after_reset_latency", 32'(n), 32'd1);
        host_req = 1'b0;
        @(negedge clock);
        r0 = rd_cmds;
        host_txn(1'b0, 12'd3, '0, 2);
        check_output("host_read_cmd_count", 32'(rd_cmds - r0), 32'd1);

        // Wrapping burst at the top of the address space.
        @(negedge clock);
        ready_mode = 0;
        r0 = rd_cmds; d0 = done_seen;
        apply_stimulus_burst(12'd4092, 12'd6);
        check_output("busy_after_start", 32'(strm_busy), 32'd1);
        wait_done(d0, "burst_wrap");
        check_output("burst_wrap_reads", 32'(rd_cmds - r0), 32'd6);
        repeat (2) @(negedge clock);

        // Toggling ready: stalls must neither drop nor repeat rows.
        ready_mode = 1;
        r0 = rd_cmds; d0 = done_seen;
        apply_stimulus_burst(12'd100, 12'd8);
        wait_done(d0, "burst_toggle");
        check_output("burst_toggle_reads", 32'(rd_cmds - r0), 32'd8);
        repeat (2) @(negedge clock);

        // Empty burst, then a start pulse while busy that must be ignored.
        ready_mode = 0;
        r0 = rd_cmds;
        apply_stimulus_burst(12'd200, 12'd0);
        check_output("len0_done", 32'(strm_done), 32'd1);
        check_output("len0_valid", 32'(strm_valid), 32'd0);
        check_output("len0_busy_pulse", 32'(strm_busy), 32'd1);
        @(negedge clock);
        check_output("len0_busy_drop", 32'(strm_busy), 32'd0);
        check_output("len0_no_reads", 32'(rd_cmds - r0), 32'd0);
        @(negedge clock);
        r0 = rd_cmds; d0 = done_seen;
        apply_stimulus_burst(12'd300, 12'd4);
        strm_start = 1'b1; strm_base = 12'd900; strm_len = 12'd5;
        @(negedge clock);
        strm_start = 1'b0;
        wait_done(d0, "busy_ignore");
        repeat (6) @(negedge clock);
        check_output("busy_ignore_reads", 32'(rd_cmds - r0), 32'd4);

        // Host read arriving mid-burst shares the bank.
        r0 = rd_cmds; d0 = done_seen;
        fork
            begin
                apply_stimulus_burst(12'd500, 12'd10);
                wait_done(d0, "burst_host_mix");
            end
            begin
                repeat (4) @(negedge clock);
                host_txn(1'b0, 12'd3000, '0, 0);
            end
        join
        check_output("burst_host_mix_reads", 32'(rd_cmds - r0), 32'd11);
        repeat (2) @(negedge clock);

        // Simultaneous host request and burst start: host is served first.
        d0 = done_seen; b0 = beats_seen;
        fork
            begin
                host_txn(1'b1, 12'd3100, 15'h1234, 1);
                check_output("host_before_stream", 32'(beats_seen - b0), 32'd0);
            end
            begin
                apply_stimulus_burst(12'd600, 12'd3);
                wait_done(d0, "host_first_burst");
            end
        join
        repeat (2) @(negedge clock);

        // Reset in the middle of a burst, then a fresh short burst.
        b0 = beats_seen;
        apply_stimulus_burst(12'd700, 12'd8);
        n = 0;
        while (beats_seen < b0 + 3 && n < 100) begin
            @(negedge clock);
            n++;
        end
        #2 reset = 1'b0;
        #1;
        check_output("async_reset_valid", 32'(strm_valid), 32'd0);
        check_output("async_reset_busy", 32'(strm_busy), 32'd0);
        check_output("async_reset_bank_control", 32'(bank_control), 32'd0);
        check_output("async_reset_strm_data", 32'(strm_data), 32'd0);
        check_output("async_reset_done", 32'(strm_done), 32'd0);
        strm_q.delete();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        r0 = rd_cmds; d0 = done_seen;
        apply_stimulus_burst(12'd710, 12'd2);
        wait_done(d0, "post_reset_burst");
        check_output("post_reset_reads", 32'(rd_cmds - r0), 32'd2);
        repeat (2) @(negedge clock);

        // Random bursts with random ready and a random host access each round.
        ready_mode = 2;
        for (int it = 0; it < 6; it++) begin
            base = AW'($urandom_range(0, 2000));
            len  = AW'($urandom_range(1, 12));
            d0 = done_seen;
            fork
                begin
                    apply_stimulus_burst(base, len);
                    wait_done(d0, "random_burst");
                end
                begin
                    repeat ($urandom_range(0, 6)) @(negedge clock);
                    host_txn(1'($urandom_range(0, 1)), AW'($urandom_range(3000, 3500)),
                             RW'($urandom), 0);
                end
            join
            repeat (2) @(negedge clock);
        end

        repeat (4) @(negedge clock);
        check_output("strm_queue_empty", 32'(strm_q.size()), 32'd0);
        check_output("host_queue_empty", 32'(host_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
